jtag_cmd_chain: RTL and testbench
=================================

JTAG_CMD_CHAIN -- requirements
Module: jtag_cmd_chain

Interface
REQ-001 SHALL have parameter NUM_CHAINS, default 2 (range 1..4): number of JTAG user chains served.
REQ-002 SHALL have parameter ADDR_W, default 9: command address width.
REQ-003 SHALL have parameter DATA_W, default 32: command data width.
REQ-004 SHALL have parameter RD_TIMEOUT, default 15: maximum JTCK cycles to wait for read data.
REQ-005 Derived widths: CH_W = max(1, clog2(NUM_CHAINS)); FRAME_W = 2 + ADDR_W + DATA_W.
REQ-006 JTCK  in  1  sole clock; all logic on rising edge.
REQ-007 JRSTN  in  1  asynchronous, active-low reset.
REQ-008 JTDI  in  1  serial data in.
REQ-009 JSHIFT  in  1  Shift-DR active.
REQ-010 JUPDATE  in  1  Update-DR active.
REQ-011 JCE  in  NUM_CHAINS  per-chain enable, high in Capture-DR and Shift-DR.
REQ-012 JRTI  in  NUM_CHAINS  per-chain Run-Test-Idle.
REQ-013 JTDO  out  NUM_CHAINS  per-chain serial data out.
REQ-014 bus_valid  out  1  one-cycle command strobe.
REQ-015 bus_we  out  1  1 = write, 0 = read.
REQ-016 bus_chain  out  CH_W  index of the issuing chain.
REQ-017 bus_addr  out  ADDR_W  command address.
REQ-018 bus_wdata  out  DATA_W  write data.
REQ-019 bus_rvalid  in  1  read data valid.
REQ-020 bus_rdata  in  DATA_W  read data.
REQ-021 commit  out  NUM_CHAINS  one-cycle per-chain commit pulse (buffer-switch trigger).
REQ-022 status  out  4  {busy, overrun, timeout, rd_ok}.

Function
REQ-023 Active chain: lowest index i with JCE[i]=1; it is latched as cur_chain for the rest of the scan.
REQ-024 Capture: in the first cycle of JCE[i]=1 with JSHIFT=0, shift_reg SHALL load {rd_hold, last_addr, rd_ok, timeout}, with bits [1:0] = {rd_ok, timeout}.
REQ-025 Shift: when JSHIFT=1 and any JCE is set, shift_reg SHALL shift right with JTDI into bit FRAME_W-1.
REQ-026 JTDO[i] SHALL equal shift_reg[0] when i = cur_chain, else 0.
REQ-027 Frame decode on JUPDATE: op = bits [1:0], addr = bits [ADDR_W+1:2], data = upper DATA_W bits.
REQ-028 op 00 = NOP; 01 = WRITE; 10 = READ; 11 = WRITE_INC.
REQ-029 WRITE SHALL use the frame addr and set auto_addr = addr + 1, mod 2^ADDR_W.
REQ-030 WRITE_INC SHALL ignore the frame addr, use auto_addr, then increment auto_addr with wrap to 0.
REQ-031 FSM states SHALL be IDLE, ISSUE, WAIT_RD.
REQ-032 IDLE -> ISSUE on a non-NOP JUPDATE.
REQ-033 ISSUE lasts one cycle: bus_valid=1 and bus_* valid. Write -> IDLE; read -> WAIT_RD.
REQ-034 WAIT_RD on bus_rvalid: rd_hold <= bus_rdata, rd_ok=1, timeout=0, -> IDLE.
REQ-035 WAIT_RD after RD_TIMEOUT cycles without bus_rvalid: timeout=1, rd_ok=0, rd_hold unchanged, -> IDLE.
REQ-036 bus_rvalid in the same cycle as the timeout expiry SHALL be treated as success.
REQ-037 JUPDATE while not IDLE: command dropped, overrun=1 (sticky until a NOP update).
REQ-038 A NOP update SHALL clear overrun.
REQ-039 rd_ok SHALL be cleared when a new READ is issued.
REQ-040 busy = (state != IDLE).
REQ-041 commit[i] SHALL pulse for one cycle on a JRTI[i] rising edge, only if a write was issued on chain i since its last commit.

Reset
REQ-042 JRSTN low SHALL, asynchronously and at any time (including mid-command), clear: shift_reg, auto_addr, rd_hold, last_addr, cur_chain, all flags, FSM (-> IDLE), and all outputs to 0.
REQ-043 A read pending at reset SHALL be abandoned, and any later bus_rvalid ignored.

Structure
REQ-044 Shared package jtag_cmd_pkg SHALL hold the op encodings, FSM state type and frame field offsets.
REQ-045 One sub-module, jtag_shift_reg (capture/shift/TDO, parametrised FRAME_W), SHALL be used; FSM and bus logic stay top-level.

Verification
REQ-046 WRITE addr 0x005 data 0xDEADBEEF on chain 0 -> one bus_valid with we=1, chain=0, addr=0x005, wdata=0xDEADBEEF.
REQ-047 Then two WRITE_INC frames -> bus_addr 0x006, then 0x007. After WRITE to 0x1FF, WRITE_INC -> addr 0x000.
REQ-048 READ 0x010 on chain 1, bus_rvalid after 3 cycles with 0x12345678 -> next capture scan on chain 1 returns data 0x12345678, rd_ok=1, timeout=0.
REQ-049 READ with no bus_rvalid -> timeout=1 after 15 cycles, busy=0. A second JUPDATE during WAIT_RD -> overrun=1, no bus_valid.
REQ-050 JCE=2'b11 -> chain 0 served, JTDO[1]=0. WRITE on chain 1 then JRTI[1] rising -> commit=2'b10 for one cycle; a second JRTI edge with no write -> no pulse.
REQ-051 JRSTN asserted during WAIT_RD -> all outputs 0 immediately. Late bus_rvalid -> no effect.

Source files
------------

// File: rtl/jtag_cmd_pkg.sv
// jtag_cmd_pkg: shared op encodings, FSM state type and frame field offsets
package jtag_cmd_pkg;
  typedef enum logic [1:0] {
    OP_NOP       = 2'b00,
    OP_WRITE     = 2'b01,
    OP_READ      = 2'b10,
    OP_WRITE_INC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RD
  } state_e;

  localparam int OP_LSB   = 0;
  localparam int ADDR_LSB = 2;
endpackage

// File: rtl/jtag_shift_reg.sv
// jtag_shift_reg: DR capture/shift register with per-chain TDO fan-out
module jtag_shift_reg #(
  parameter int FRAME_W    = 43,
  parameter int NUM_CHAINS = 2,
  parameter int CH_W       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_ce_any,
  input  logic                  i_ce_first,
  input  logic                  i_shift,
  input  logic                  i_tdi,
  input  logic [CH_W-1:0]       i_cur_chain,
  input  logic [FRAME_W-1:0]    i_cap_data,
  output logic [FRAME_W-1:0]    o_frame,
  output logic [NUM_CHAINS-1:0] o_tdo
);
  logic [FRAME_W-1:0] r_sr;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sr <= '0;
    else if (i_ce_first && !i_shift) r_sr <= i_cap_data;
    else if (i_shift && i_ce_any) r_sr <= {i_tdi, r_sr[FRAME_W-1:1]};

  always_comb
    for (int i = 0; i < NUM_CHAINS; i++) o_tdo[i] = (CH_W'(i) == i_cur_chain) && r_sr[0];

  assign o_frame = r_sr;
endmodule

// File: rtl/jtag_cmd_chain.sv
// jtag_cmd_chain: JTAG user-chain command decoder issuing bus reads/writes,
// with read-back capture, timeout/overrun status and per-chain commit pulses
module jtag_cmd_chain
  import jtag_cmd_pkg::*;
#(
  parameter int NUM_CHAINS = 2,
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int RD_TIMEOUT = 15,
  localparam int CH_W      = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1,
  localparam int FRAME_W   = 2 + ADDR_W + DATA_W
) (
  input  logic                  JTCK,
  input  logic                  JRSTN,
  input  logic                  JTDI,
  input  logic                  JSHIFT,
  input  logic                  JUPDATE,
  input  logic [NUM_CHAINS-1:0] JCE,
  input  logic [NUM_CHAINS-1:0] JRTI,
  output logic [NUM_CHAINS-1:0] JTDO,
  output logic                  bus_valid,
  output logic                  bus_we,
  output logic [CH_W-1:0]       bus_chain,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_rvalid,
  input  logic [DATA_W-1:0]     bus_rdata,
  output logic [NUM_CHAINS-1:0] commit,
  output logic [3:0]            status
);
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  state_e                r_state;
  logic                  r_ce_d;
  logic [CH_W-1:0]       r_cur_chain;
  logic [ADDR_W-1:0]     r_auto_addr;
  logic [ADDR_W-1:0]     r_last_addr;
  logic [DATA_W-1:0]     r_rd_hold;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_rd_ok;
  logic                  r_timeout;
  logic                  r_overrun;
  logic                  r_bus_valid;
  logic                  r_bus_we;
  logic [CH_W-1:0]       r_bus_chain;
  logic [ADDR_W-1:0]     r_bus_addr;
  logic [DATA_W-1:0]     r_bus_wdata;
  logic [NUM_CHAINS-1:0] r_rti_d;
  logic [NUM_CHAINS-1:0] r_dirty;
  logic [NUM_CHAINS-1:0] r_commit;

  logic                  w_ce_any;
  logic                  w_ce_first;
  logic [CH_W-1:0]       w_pri;
  logic [FRAME_W-1:0]    w_frame;
  op_e                   w_op;
  logic [ADDR_W-1:0]     w_addr;
  logic [DATA_W-1:0]     w_data;
  logic                  w_is_wr;
  logic [ADDR_W-1:0]     w_iss_addr;
  logic                  w_start;
  logic [NUM_CHAINS-1:0] w_wr_set;
  logic [NUM_CHAINS-1:0] w_rti_rise;

  assign w_ce_any   = |JCE;
  assign w_ce_first = w_ce_any && !r_ce_d;

  always_comb begin
    w_pri = '0;
    for (int i = NUM_CHAINS - 1; i >= 0; i--) if (JCE[i]) w_pri = CH_W'(i);
  end

  jtag_shift_reg #(
    .FRAME_W   (FRAME_W),
    .NUM_CHAINS(NUM_CHAINS),
    .CH_W      (CH_W)
  ) u_sr (
    .clk        (JTCK),
    .rst_n      (JRSTN),
    .i_ce_any   (w_ce_any),
    .i_ce_first (w_ce_first),
    .i_shift    (JSHIFT),
    .i_tdi      (JTDI),
    .i_cur_chain(r_cur_chain),
    .i_cap_data ({r_rd_hold, r_last_addr, r_rd_ok, r_timeout}),
    .o_frame    (w_frame),
    .o_tdo      (JTDO)
  );

  assign w_op       = op_e'(w_frame[OP_LSB +: 2]);
  assign w_addr     = w_frame[ADDR_LSB +: ADDR_W];
  assign w_data     = w_frame[FRAME_W-1 -: DATA_W];
  assign w_is_wr    = (w_op == OP_WRITE) || (w_op == OP_WRITE_INC);
  assign w_iss_addr = (w_op == OP_WRITE_INC) ? r_auto_addr : w_addr;
  assign w_start    = JUPDATE && (r_state == S_IDLE) && (w_op != OP_NOP);
  assign w_wr_set   = (w_start && w_is_wr) ? (NUM_CHAINS'(1) << r_cur_chain) : '0;
  assign w_rti_rise = JRTI & ~r_rti_d;

  always_ff @(posedge JTCK or negedge JRSTN)
    if (!JRSTN) begin
      r_state     <= S_IDLE;
      r_ce_d      <= 1'b0;
      r_cur_chain <= '0;
      r_auto_addr <= '0;
      r_last_addr <= '0;
      r_rd_hold   <= '0;
      r_cnt       <= '0;
      r_rd_ok     <= 1'b0;
      r_timeout   <= 1'b0;
      r_overrun   <= 1'b0;
      r_bus_valid <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_chain <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else begin
      r_bus_valid <= 1'b0;
      r_ce_d      <= w_ce_any;
      if (w_ce_first) r_cur_chain <= w_pri;
      // A NOP update clears overrun at any time; real commands while busy are dropped
      if (JUPDATE && w_op == OP_NOP) r_overrun <= 1'b0;
      else if (JUPDATE && r_state != S_IDLE) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE:
          if (w_start) begin
            r_state     <= S_ISSUE;
            r_bus_valid <= 1'b1;
            r_bus_we    <= w_is_wr;
            r_bus_chain <= r_cur_chain;
            r_bus_addr  <= w_iss_addr;
            r_bus_wdata <= w_data;
            r_last_addr <= w_iss_addr;
            if (w_is_wr) r_auto_addr <= w_iss_addr + ADDR_W'(1);
            else r_rd_ok <= 1'b0;
          end
        S_ISSUE: begin
          r_state <= r_bus_we ? S_IDLE : S_WAIT_RD;
          r_cnt   <= '0;
        end
        S_WAIT_RD:
          if (bus_rvalid) begin
            r_rd_hold <= bus_rdata;
            r_rd_ok   <= 1'b1;
            r_timeout <= 1'b0;
            r_state   <= S_IDLE;
          end else if (r_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
            r_rd_ok   <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
          end else r_cnt <= r_cnt + CNT_W'(1);
        default: r_state <= S_IDLE;
      endcase
    end

  always_ff @(posedge JTCK or negedge JRSTN)
    if (!JRSTN) begin
      r_rti_d  <= '0;
      r_dirty  <= '0;
      r_commit <= '0;
    end else begin
      r_rti_d  <= JRTI;
      r_commit <= w_rti_rise & r_dirty;
      r_dirty  <= (r_dirty & ~w_rti_rise) | w_wr_set;
    end

  assign bus_valid = r_bus_valid;
  assign bus_we    = r_bus_we;
  assign bus_chain = r_bus_chain;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign commit    = r_commit;
  assign status    = {r_state != S_IDLE, r_overrun, r_timeout, r_rd_ok};
endmodule

// File: tb/tb_jtag_cmd_chain.sv
// tb_jtag_cmd_chain: directed vector table plus hand-written multi-cycle sequences
module tb_jtag_cmd_chain;
  logic        JTCK = 0;
  logic        JRSTN = 0;
  logic        JTDI = 0;
  logic        JSHIFT = 0;
  logic        JUPDATE = 0;
  logic [1:0]  JCE = 0;
  logic [1:0]  JRTI = 0;
  logic [1:0]  JTDO;
  logic        bus_valid;
  logic        bus_we;
  logic [0:0]  bus_chain;
  logic [8:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rvalid = 0;
  logic [31:0] bus_rdata = 0;
  logic [1:0]  commit;
  logic [3:0]  status;

  int n_chk = 0;
  int n_fail = 0;
  int n_valid = 0;

  jtag_cmd_chain dut (
    .JTCK(JTCK), .JRSTN(JRSTN), .JTDI(JTDI), .JSHIFT(JSHIFT), .JUPDATE(JUPDATE),
    .JCE(JCE), .JRTI(JRTI), .JTDO(JTDO), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_chain(bus_chain), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .commit(commit), .status(status)
  );

  always #5 JTCK = ~JTCK;
  always @(posedge JTCK) if (bus_valid === 1'b1) n_valid++;

  typedef struct {
    int          ch;
    logic [1:0]  op;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [8:0]  exp_addr;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge JTCK);
  endtask

  function automatic logic [42:0] fr(input logic [1:0] op, input logic [8:0] a, input logic [31:0] d);
    return {d, a, op};
  endfunction

  // Capture, shift a full frame in (recording what comes out), then one Update cycle
  task automatic scan(input int ch, input logic [42:0] frame, output logic [42:0] cap);
    JCE = '0;
    JCE[ch] = 1'b1;
    JSHIFT = 0;
    tick();
    JSHIFT = 1;
    for (int k = 0; k < 43; k++) begin
      cap[k] = JTDO[ch];
      JTDI = frame[k];
      tick();
    end
    JSHIFT = 0;
    JCE = '0;
    JTDI = 0;
    JUPDATE = 1;
    tick();
    JUPDATE = 0;
  endtask

  initial begin
    vec_t        v[6];
    logic [42:0] cap;
    int          n, v0;
    v[0] = '{0, 2'b01, 9'h005, 32'hDEADBEEF, 9'h005};
    v[1] = '{0, 2'b11, 9'h0AA, 32'h00000001, 9'h006};
    v[2] = '{0, 2'b11, 9'h0AA, 32'h00000002, 9'h007};
    v[3] = '{0, 2'b01, 9'h1FF, 32'h00000003, 9'h1FF};
    v[4] = '{0, 2'b11, 9'h055, 32'h00000004, 9'h000};
    v[5] = '{1, 2'b01, 9'h020, 32'h00000005, 9'h020};

    repeat (3) tick();
    chk("rst_valid", bus_valid, 0);
    chk("rst_status", status, 0);
    chk("rst_commit", commit, 0);
    chk("rst_tdo", JTDO, 0);
    chk("rst_addr", bus_addr, 0);
    JRSTN = 1;
    tick();

    for (int i = 0; i < 6; i++) begin
      scan(v[i].ch, fr(v[i].op, v[i].addr, v[i].data), cap);
      chk($sformatf("v%0d_valid", i), bus_valid, 1);
      chk($sformatf("v%0d_we", i), bus_we, 1);
      chk($sformatf("v%0d_chain", i), bus_chain, 64'(v[i].ch));
      chk($sformatf("v%0d_addr", i), bus_addr, v[i].exp_addr);
      chk($sformatf("v%0d_wdata", i), bus_wdata, v[i].data);
      tick();
      chk($sformatf("v%0d_valid_off", i), bus_valid, 0);
      chk($sformatf("v%0d_idle", i), status[3], 0);
    end

    JRTI = 2'b10;
    tick();
    chk("commit1", commit, 2'b10);
    tick();
    chk("commit1_off", commit, 2'b00);
    JRTI = 2'b00;
    tick();
    JRTI = 2'b10;
    tick();
    chk("commit1_again", commit, 2'b00);
    JRTI = 2'b11;
    tick();
    chk("commit0", commit, 2'b01);
    JRTI = 2'b00;
    tick();

    scan(1, fr(2'b10, 9'h010, 32'h0), cap);
    chk("rd_valid", bus_valid, 1);
    chk("rd_we", bus_we, 0);
    chk("rd_chain", bus_chain, 1);
    chk("rd_addr", bus_addr, 9'h010);
    repeat (3) tick();
    bus_rvalid = 1;
    bus_rdata = 32'h12345678;
    tick();
    bus_rvalid = 0;
    chk("rd_status", status, 4'b0001);
    scan(1, fr(2'b00, 9'h0, 32'h0), cap);
    chk("rd_capture", cap, {32'h12345678, 9'h010, 1'b1, 1'b0});
    chk("nop_no_valid", bus_valid, 0);

    scan(0, fr(2'b10, 9'h030, 32'h0), cap);
    chk("to_valid", bus_valid, 1);
    n = 0;
    while (status[3] && n < 40) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 16);
    chk("to_status", status, 4'b0010);

    scan(0, fr(2'b10, 9'h040, 32'h0), cap);
    tick();
    v0 = n_valid;
    tick();
    JUPDATE = 1;
    tick();
    JUPDATE = 0;
    chk("ovr_busy", status[3:2], 2'b11);
    n = 0;
    while (status[3] && n < 40) begin
      tick();
      n++;
    end
    chk("ovr_no_valid", n_valid - v0, 0);
    chk("ovr_status", status, 4'b0110);

    JCE = 2'b11;
    tick();
    chk("ce11_tdo", JTDO, 2'b01);
    JCE = 2'b00;
    tick();
    scan(0, fr(2'b00, 9'h0, 32'h0), cap);
    chk("nop_clears_ovr", status, 4'b0010);
    chk("to_capture", cap, {32'h12345678, 9'h040, 1'b0, 1'b1});

    scan(0, fr(2'b10, 9'h060, 32'h0), cap);
    repeat (15) tick();
    bus_rvalid = 1;
    bus_rdata = 32'hCAFEF00D;
    tick();
    bus_rvalid = 0;
    chk("edge_rvalid_status", status, 4'b0001);

    scan(0, fr(2'b10, 9'h050, 32'hABCD), cap);
    repeat (2) tick();
    #2 JRSTN = 0;
    #1;
    chk("arst_valid", bus_valid, 0);
    chk("arst_addr", bus_addr, 0);
    chk("arst_wdata", bus_wdata, 0);
    chk("arst_status", status, 0);
    chk("arst_tdo", JTDO, 0);
    tick();
    JRSTN = 1;
    bus_rvalid = 1;
    bus_rdata = 32'h55AA55AA;
    tick();
    bus_rvalid = 0;
    tick();
    chk("late_rvalid_status", status, 0);
    scan(0, fr(2'b00, 9'h0, 32'h0), cap);
    chk("post_rst_capture", cap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
